// File: rtl/dspl_mux_drv_pkg.sv
// Shared glyph codes and active-low 7-segment patterns for display blocks.
// Latency: none (constants only).
// Backpressure: not applicable.
package dspl_pkg;

  // Letter/symbol codes; 0x00-0x09 are the decimal digits themselves
  localparam logic [4:0] CODE_P     = 5'h0A;
  localparam logic [4:0] CODE_B     = 5'h0B;
  localparam logic [4:0] CODE_C     = 5'h0C;
  localparam logic [4:0] CODE_S     = 5'h0D;
  localparam logic [4:0] CODE_E     = 5'h0E;
  localparam logic [4:0] CODE_U     = 5'h0F;
  localparam logic [4:0] CODE_R     = 5'h10;
  localparam logic [4:0] CODE_DASH  = 5'h11;
  localparam logic [4:0] CODE_BLANK = 5'h1F;

  // Segment order {a,b,c,d,e,f,g}; a 0 lights the segment
  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam logic [6:0] GLYPH_0    = 7'b0000001;
  localparam logic [6:0] GLYPH_1    = 7'b1001111;
  localparam logic [6:0] GLYPH_2    = 7'b0010010;
  localparam logic [6:0] GLYPH_3    = 7'b0000110;
  localparam logic [6:0] GLYPH_4    = 7'b1001100;
  localparam logic [6:0] GLYPH_5    = 7'b0100100;
  localparam logic [6:0] GLYPH_6    = 7'b0100000;
  localparam logic [6:0] GLYPH_7    = 7'b0001111;
  localparam logic [6:0] GLYPH_8    = 7'b0000000;
  localparam logic [6:0] GLYPH_9    = 7'b0000100;
  localparam logic [6:0] GLYPH_P    = 7'b0011000;
  localparam logic [6:0] GLYPH_B    = 7'b1100000;
  localparam logic [6:0] GLYPH_C    = 7'b0110001;
  localparam logic [6:0] GLYPH_S    = 7'b0100100;
  localparam logic [6:0] GLYPH_E    = 7'b0110000;
  localparam logic [6:0] GLYPH_U    = 7'b1000001;
  localparam logic [6:0] GLYPH_R    = 7'b1111010;
  localparam logic [6:0] GLYPH_DASH = 7'b1111110;

endpackage

// File: rtl/dspl_mux_drv_if.sv
// Bundle between the application datapath and the display pin driver.
// Latency: none (wires only).
// Backpressure: none; glyph inputs are sampled whenever a digit slot opens.
interface dspl_mux_drv_if #(
  parameter int N_DIGITS = 8
);
  logic [6*N_DIGITS-1:0] digits;      // per digit {enable, code[4:0]}
  logic [N_DIGITS-1:0]   dp;
  logic [N_DIGITS-1:0]   blink;
  logic [3:0]            brightness;
  logic [N_DIGITS-1:0]   an;          // active-low anodes
  logic [6:0]            seg;         // active-low cathodes {a..g}
  logic                  dp_n;
  logic                  frame_tick;

  modport master (
    output digits, dp, blink, brightness,
    input  an, seg, dp_n, frame_tick
  );

  modport slave (
    input  digits, dp, blink, brightness,
    output an, seg, dp_n, frame_tick
  );
endinterface

// File: rtl/dspl_mux_drv_glyph.sv
// Combinational 5-bit glyph code to active-low 7-segment pattern.
// Latency: 0 cycles.
// Backpressure: not applicable; undefined codes decode to all segments off.
module seg7_glyph_dec
  import dspl_pkg::*;
(
  input  logic [4:0] i_code,
  output logic [6:0] o_seg
);

  // Code lookup; anything not listed is blank
  always_comb begin
    o_seg = SEG_OFF;
    case (i_code)
      5'h00:     o_seg = GLYPH_0;
      5'h01:     o_seg = GLYPH_1;
      5'h02:     o_seg = GLYPH_2;
      5'h03:     o_seg = GLYPH_3;
      5'h04:     o_seg = GLYPH_4;
      5'h05:     o_seg = GLYPH_5;
      5'h06:     o_seg = GLYPH_6;
      5'h07:     o_seg = GLYPH_7;
      5'h08:     o_seg = GLYPH_8;
      5'h09:     o_seg = GLYPH_9;
      CODE_P:    o_seg = GLYPH_P;
      CODE_B:    o_seg = GLYPH_B;
      CODE_C:    o_seg = GLYPH_C;
      CODE_S:    o_seg = GLYPH_S;
      CODE_E:    o_seg = GLYPH_E;
      CODE_U:    o_seg = GLYPH_U;
      CODE_R:    o_seg = GLYPH_R;
      CODE_DASH: o_seg = GLYPH_DASH;
      default:   o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/dspl_mux_drv.sv
// Time-multiplexed common-anode 7-segment driver with dp, blink, PWM dimming.
// Latency: segments follow a slot entry by 1 cycle; anodes after BLANK_COUNT more.
// Backpressure: none; inputs are snapshotted per slot, mid-slot changes wait.
module dspl_mux_drv
  import dspl_pkg::*;
#(
  parameter int N_DIGITS      = 8,
  parameter int REFRESH_COUNT = 100000,
  parameter int BLANK_COUNT   = 1000,
  parameter int BLINK_FRAMES  = 64
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  dspl_mux_drv_if.slave    bus
);

  localparam int CW = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT) : 1;
  localparam int KW = (N_DIGITS > 1)      ? $clog2(N_DIGITS)      : 1;
  localparam int FW = (BLINK_FRAMES > 1)  ? $clog2(BLINK_FRAMES)  : 1;

  if (N_DIGITS < 1 || N_DIGITS > 16 || BLANK_COUNT < 0 ||
      BLANK_COUNT >= REFRESH_COUNT || BLINK_FRAMES < 1) begin : g_bad_params
    $error("dspl_mux_drv: illegal parameter combination");
  end

  logic [CW-1:0]       r_c;
  logic [KW-1:0]       r_k;
  logic [3:0]          r_p;
  logic [FW-1:0]       r_fcnt;
  logic                r_blink_ph;
  logic                r_first;
  logic                r_sn_en;
  logic [4:0]          r_sn_code;
  logic                r_sn_dp;
  logic                r_sn_blink;
  logic [3:0]          r_sn_bright;
  logic [N_DIGITS-1:0] r_an;
  logic [6:0]          r_seg;
  logic                r_dp_n;
  logic                r_tick;

  logic                w_wrap;
  logic                w_k_last;
  logic                w_entry;
  logic                w_fstart;
  logic [KW-1:0]       w_k_next;
  logic [5:0]          w_dig;
  logic [6:0]          w_glyph;
  logic                w_pwm_on;
  logic                w_an_on;
  logic [N_DIGITS-1:0] w_an_sel;

  assign w_wrap   = (r_c == CW'(REFRESH_COUNT - 1));
  assign w_k_last = (r_k == KW'(N_DIGITS - 1));
  // The first edge out of reset opens slot 0 without waiting a full slot
  assign w_entry  = w_wrap || r_first;
  assign w_fstart = w_wrap && w_k_last;

  // Slot index that becomes current after this edge
  always_comb begin
    w_k_next = r_k;
    if (w_wrap) begin
      w_k_next = w_k_last ? '0 : r_k + KW'(1);
    end
  end

  assign w_dig = bus.digits[6*int'(w_k_next) +: 6];

  seg7_glyph_dec u_glyph (
    .i_code (r_sn_code),
    .o_seg  (w_glyph)
  );

  // Anode rule works on the pre-edge slot so the old digit holds until its
  // segments are replaced on the cycle after entry (no ghosting overlap)
  assign w_pwm_on = (r_sn_bright == 4'hF) || (r_p < r_sn_bright);
  assign w_an_on  = (r_c >= CW'(BLANK_COUNT)) && r_sn_en &&
                    !(r_sn_blink && r_blink_ph) && w_pwm_on;
  assign w_an_sel = w_an_on ? (N_DIGITS'(1) << r_k) : '0;

  // Prescaler and slot index
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_c     <= '0;
      r_k     <= '0;
      r_first <= 1'b1;
    end else begin
      r_c     <= w_wrap ? '0 : r_c + CW'(1);
      r_k     <= w_k_next;
      r_first <= 1'b0;
    end
  end

  // Per-slot snapshot of the digit being entered
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sn_en     <= 1'b0;
      r_sn_code   <= CODE_BLANK;
      r_sn_dp     <= 1'b0;
      r_sn_blink  <= 1'b0;
      r_sn_bright <= 4'h0;
    end else if (w_entry) begin
      r_sn_en     <= w_dig[5];
      r_sn_code   <= w_dig[4:0];
      r_sn_dp     <= bus.dp[w_k_next];
      r_sn_blink  <= bus.blink[w_k_next];
      r_sn_bright <= bus.brightness;
    end
  end

  // Free-running PWM phase, frame counter and blink phase
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_p        <= 4'h0;
      r_fcnt     <= '0;
      r_blink_ph <= 1'b0;
    end else begin
      r_p <= r_p + 4'h1;
      if (w_fstart) begin
        if (r_fcnt == FW'(BLINK_FRAMES - 1)) begin
          r_fcnt     <= '0;
          r_blink_ph <= ~r_blink_ph;
        end else begin
          r_fcnt <= r_fcnt + FW'(1);
        end
      end
    end
  end

  // Registered pin outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_an   <= '1;
      r_seg  <= SEG_OFF;
      r_dp_n <= 1'b1;
      r_tick <= 1'b0;
    end else begin
      r_an   <= ~w_an_sel;
      r_seg  <= w_glyph;
      r_dp_n <= ~r_sn_dp;
      r_tick <= w_fstart;
    end
  end

  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.dp_n       = r_dp_n;
  assign bus.frame_tick = r_tick;

endmodule

// File: doc/dspl_mux_drv.md
# dspl_mux_drv

Parametrised, time-multiplexed 7-segment display driver for N common-anode digits with per-digit decimal point, blink and PWM brightness. Each digit is scanned with a synchronous clock-enable prescaler (no derived clocks) and an anti-ghosting blanking guard. It sits between the application datapath, which supplies per-digit glyph codes, and the board's anode/cathode pins.

## Interface
- N_DIGITS, 8, digits scanned (1..16)
- REFRESH_COUNT, 100000, clock cycles per digit slot (1 ms at 100 MHz)
- BLANK_COUNT, 1000, guard cycles at slot start with all anodes off (0 ≤ BLANK_COUNT < REFRESH_COUNT; elaboration error otherwise)
- BLINK_FRAMES, 64, full scan frames per blink half-period (≥1)
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- digits  in  6*N_DIGITS  per digit i, bits [6i+5:6i] = {enable, code[4:0]}; digit 0 = rightmost
- dp  in  N_DIGITS  decimal point request per digit, active-high
- blink  in  N_DIGITS  blink request per digit, active-high
- brightness  in  4  PWM duty: 0 = off, 1..14 = n/16, 15 = always on
- an  out  N_DIGITS  anode enables, active-low, registered
- seg  out  7  cathodes {a,b,c,d,e,f,g}, active-low, registered
- dp_n  out  1  decimal-point cathode, active-low, registered
- frame_tick  out  1  one-cycle pulse at the start of each full scan, registered

## Operation
- Prescaler c counts 0..REFRESH_COUNT-1 every clock; wrap marks a slot entry.
- Slot index k advances on each slot entry, wrapping N_DIGITS-1 → 0. With N_DIGITS=1, k stays 0.
- On each slot entry, and on the first edge after reset release, a snapshot captures for slot k: enable, code, dp, blink and brightness. Inputs changing mid-slot are ignored until slot k is next entered.
- Glyph decode from snapshot code: 0x0-0x9 digits, 0xA P, 0xB b, 0xC C, 0xD S, 0xE E, 0xF U, 0x10 r, 0x11 '-'. 0x1F and all undefined codes are blank (all segments off).
- dp_n = ~snapshot dp.
- Anode k is driven low only when all of the following hold:
  - c ≥ BLANK_COUNT;
  - snapshot enable is 1;
  - not (snapshot blink and blink_phase);
  - PWM is on.
  All other anodes are high.
- PWM: a 4-bit counter p free-runs every clock. PWM is on when brightness==15 or p < brightness.
- Frame counter counts frame starts 0..BLINK_FRAMES-1. On wrap, blink_phase toggles.
- frame_tick pulses for one cycle when k wraps to 0.

## Timing
- Reset (asynchronous, at any time, including mid-slot) forces:
  - outputs: an all 1, seg 7'h7F, dp_n 1, frame_tick 0;
  - internal state: c, k, p, frame counter, blink_phase all 0; snapshot cleared (enable 0).
- Let E be the slot-entry edge.
  - seg and dp_n show the new digit from E+1.
  - an is all-high from E+1 through E+BLANK_COUNT, then follows the anode rule until the next entry edge.
- On the next entry edge, an and seg change together, so the old anode never overlaps the new segments. With BLANK_COUNT=0 there is no guard; this configuration is legal.
- Full frame = N_DIGITS*REFRESH_COUNT cycles. The frame_tick period equals the full frame.
- Blink period = 2*BLINK_FRAMES frames.

## Structure
- Package dspl_pkg:
  - glyph code localparams (CODE_P, CODE_S, CODE_U, CODE_R, CODE_DASH, CODE_BLANK);
  - 7-bit active-low glyph constants;
  - SEG_OFF.
- Sub-module seg7_glyph_dec: combinational 5-bit code → 7-bit active-low glyph, shared with other display blocks.
- Top: prescaler, slot counter, snapshot registers, PWM counter, frame/blink counters, output registers.

## Test plan
Bench parameters: N_DIGITS=4, REFRESH_COUNT=8, BLANK_COUNT=2, BLINK_FRAMES=2.
- Reset held low mid-scan, then released:
  - while low: an=4'hF, seg=7'h7F, dp_n=1;
  - after release: first slot-0 anode low at cycle 3.
- digits={1,0x3},{1,0x2},{1,0x1},{1,0x0}, brightness=15:
  - an cycles 1110 → 1101 → 1011 → 0111, 6 low cycles per slot;
  - seg = 0000001, 1001111, 0010010, 0000110 in slot order;
  - frame_tick every 32 cycles.
- Digit 2 enable=0 and code 0x1F on digit 1:
  - an[2] stays high throughout;
  - during slot 1, an[1] is low with seg=7'h7F.
- blink=4'b0001 → an[0] active for 2 frames, held high for 2 frames, repeating; other digits unaffected.
- brightness=4:
  - an[k] low exactly 4 of every 16 cycles within the active window;
  - brightness=0 → no anode ever low.
- Input change mid-slot (code of active digit 5 → 7 at c=4) → seg unchanged until that digit's next slot entry; dp toggle is handled the same way.
